// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus router: FSM state encoding,
// width of a region-size field, and the default three-device address map
// (memory, palette, framebuffer).
package io_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    // Width of one log2(region size) field in the packed size parameter.
    localparam int SIZE_W = 6;

    // Default map: 1 KiB memory at 0, 512 B palette at 0x800,
    // 128 KiB framebuffer at 0x20000.
    localparam logic [31:0] MEM_BASE      = 32'h0000_0000;
    localparam logic [5:0]  MEM_SIZE_LOG2 = 6'd10;
    localparam logic [31:0] PAL_BASE      = 32'h0000_0800;
    localparam logic [5:0]  PAL_SIZE_LOG2 = 6'd9;
    localparam logic [31:0] FB_BASE       = 32'h0002_0000;
    localparam logic [5:0]  FB_SIZE_LOG2  = 6'd17;

    localparam logic [95:0] DEFAULT_DEV_BASE      = {FB_BASE, PAL_BASE, MEM_BASE};
    localparam logic [17:0] DEFAULT_DEV_SIZE_LOG2 = {FB_SIZE_LOG2, PAL_SIZE_LOG2, MEM_SIZE_LOG2};

    // Width of a device index; at least one bit even for a single device.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_bus_decoder.sv
// Combinational address decoder: finds the lowest-indexed device whose
// aligned region contains the address and returns the in-region offset.
module io_bus_decoder
    import io_bus_pkg::*;
#(
    parameter int                          N_DEV         = 3,
    parameter int                          ADDR_W        = 32,
    parameter logic [N_DEV*ADDR_W-1:0]     DEV_BASE      = DEFAULT_DEV_BASE,
    parameter logic [N_DEV*SIZE_W-1:0]     DEV_SIZE_LOG2 = DEFAULT_DEV_SIZE_LOG2,
    parameter int                          SEL_W         = sel_width(N_DEV)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel,
    output logic [ADDR_W-1:0] offset
);

    logic [N_DEV-1:0]  hit_vec;
    logic [ADDR_W-1:0] offset_vec [N_DEV];

    // Per-device region match and offset; bases are size-aligned, so the
    // offset is just the address bits below the region size.
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
        localparam int               SZ   = int'(DEV_SIZE_LOG2[gi*SIZE_W +: SIZE_W]);
        localparam logic [ADDR_W-1:0] BASE = DEV_BASE[gi*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] MASK = ~({ADDR_W{1'b1}} << SZ);

        assign hit_vec[gi]    = (addr >> SZ) == (BASE >> SZ);
        assign offset_vec[gi] = addr & MASK;
    end

    // Priority select: scanning downwards lets the lowest matching index win.
    always_comb begin
        hit    = |hit_vec;
        sel    = '0;
        offset = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel    = SEL_W'(i);
                offset = offset_vec[i];
            end
        end
    end

endmodule

// File: rtl/io_bus_router.sv
// Single-outstanding bus router: accepts one request, forwards it to the
// decoded device, waits for its completion and returns a one-cycle response.
// Unmapped addresses get an immediate error response.
// Optional feature: define IO_BUS_TIMEOUT_EN to abort requests that stay in
// REQ/WAIT for TIMEOUT_CYCLES cycles with an error response.
module io_bus_router
    import io_bus_pkg::*;
#(
    parameter int                      N_DEV          = 3,
    parameter int                      ADDR_W         = 32,
    parameter int                      DATA_W         = 32,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE       = DEFAULT_DEV_BASE,
    parameter logic [N_DEV*SIZE_W-1:0] DEV_SIZE_LOG2  = DEFAULT_DEV_SIZE_LOG2,
    parameter logic [15:0]             TIMEOUT_CYCLES = 16'd255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_wr_en,
    input  logic [DATA_W-1:0]         req_wr_data,
    input  logic [DATA_W/8-1:0]       req_be,
    output logic                      rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rd_data,
    output logic [N_DEV-1:0]          dev_req_valid,
    input  logic [N_DEV-1:0]          dev_req_ready,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic                      dev_wr_en,
    output logic [DATA_W-1:0]         dev_wr_data,
    output logic [DATA_W/8-1:0]       dev_be,
    input  logic [N_DEV-1:0]          dev_rsp_valid,
    input  logic [N_DEV*DATA_W-1:0]   dev_rsp_data
);

    localparam int SEL_W = sel_width(N_DEV);
    localparam int BE_W  = DATA_W / 8;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic [BE_W-1:0]     be_reg;
    logic                wr_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   rd_data_reg;

    logic                dec_hit;
    logic [SEL_W-1:0]    dec_sel;
    logic [ADDR_W-1:0]   dec_offset;

    logic [N_DEV-1:0]    sel_onehot;
    logic                sel_ready;
    logic                sel_rsp;
    logic [DATA_W-1:0]   sel_rsp_data;
    logic                complete;
    logic                timeout;

    io_bus_decoder #(
        .N_DEV         (N_DEV),
        .ADDR_W        (ADDR_W),
        .DEV_BASE      (DEV_BASE),
        .DEV_SIZE_LOG2 (DEV_SIZE_LOG2),
        .SEL_W         (SEL_W)
    ) u_decoder (
        .addr   (req_addr),
        .hit    (dec_hit),
        .sel    (dec_sel),
        .offset (dec_offset)
    );

    // One-hot of the captured device index, used to mask every per-device input.
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_sel
        assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
    end

    assign sel_ready = |(dev_req_ready & sel_onehot);
    assign sel_rsp   = |(dev_rsp_valid & sel_onehot);
    assign complete  = ((state_reg == ST_REQ) && sel_ready && sel_rsp) ||
                       ((state_reg == ST_WAIT) && sel_rsp);

    // Pick the selected device's completion data out of the packed bus.
    always_comb begin
        sel_rsp_data = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_onehot[i]) begin
                sel_rsp_data = dev_rsp_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef IO_BUS_TIMEOUT_EN
    logic [15:0] cnt_reg;

    // Count cycles spent waiting on the device; cleared outside REQ/WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
            cnt_reg <= cnt_reg + 16'd1;
        end else begin
            cnt_reg <= '0;
        end
    end

    assign timeout = (cnt_reg == TIMEOUT_CYCLES - 16'd1);
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State register plus request capture at acceptance and data capture at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            be_reg      <= '0;
            wr_reg      <= 1'b0;
            sel_reg     <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                addr_reg    <= dec_offset;
                wr_data_reg <= req_wr_data;
                be_reg      <= req_be;
                wr_reg      <= req_wr_en;
                sel_reg     <= dec_sel;
            end
            if (complete) begin
                rd_data_reg <= wr_reg ? '0 : sel_rsp_data;
            end
        end
    end

    // Next-state and Moore outputs; completion beats timeout on the same cycle.
    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        rsp_rd_data   = '0;
        dev_req_valid = '0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = dec_hit ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                dev_req_valid = sel_onehot;
                if (complete) begin
                    state_next = ST_RESP;
                end else if (timeout) begin
                    state_next = ST_ERR;
                end else if (sel_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (complete) begin
                    state_next = ST_RESP;
                end else if (timeout) begin
                    state_next = ST_ERR;
                end
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rd_data = rd_data_reg;
                state_next  = ST_IDLE;
            end
            ST_ERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dev_addr    = addr_reg;
    assign dev_wr_en   = wr_reg;
    assign dev_wr_data = wr_data_reg;
    assign dev_be      = be_reg;

endmodule
